// File: rtl/reg128_write_arb.sv
// rtl/reg128_write_arb.sv - two-requester write arbiter for a 128-bit register with init reload
// Requester 1 may lock the write port for a burst; init reload waits for the burst to finish.
module reg128_write_arb #(
  parameter logic [127:0] INIT_VALUE = 128'h0
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  input  logic [3:0]   req1_burst,
  output logic         req1_ready,
  input  logic         init_req,
  output logic         reg_aload,
  output logic [127:0] reg_adata,
  output logic         reg_we,
  output logic [127:0] reg_wdata,
  output logic         busy,
  output logic         last_grant
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t         state_q;
  logic           rr_ptr_q;
  logic [3:0]     beat_cnt_q;
  logic           reg_aload_q;
  logic           reg_we_q;
  logic [127:0]   reg_wdata_q;
  logic           last_grant_q;
  logic           accept0;
  logic           accept1;

  // Ready is combinational so a beat can be taken in the cycle it is offered.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!init_req) begin
          if (req0_valid && req1_valid) begin
            req0_ready = !rr_ptr_q;
            req1_ready = rr_ptr_q;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
        end
      end
      ST_BURST: req1_ready = 1'b1;
      default: ;
    endcase
  end

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= ST_INIT;
      rr_ptr_q     <= 1'b0;
      beat_cnt_q   <= 4'd0;
      reg_aload_q  <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_wdata_q  <= 128'h0;
      last_grant_q <= 1'b0;
    end else begin
      reg_aload_q <= (state_q == ST_INIT);
      reg_we_q    <= accept0 || accept1;
      if (accept0) begin
        reg_wdata_q  <= req0_data;
        last_grant_q <= 1'b0;
      end else if (accept1) begin
        reg_wdata_q  <= req1_data;
        last_grant_q <= 1'b1;
      end
      case (state_q)
        ST_INIT: state_q <= ST_IDLE;
        ST_IDLE: begin
          if (init_req) begin
            state_q <= ST_INIT;
          end else begin
            if (accept0) rr_ptr_q <= 1'b1;
            if (accept1) begin
              rr_ptr_q <= 1'b0;
              if (req1_burst != 4'd0) begin
                state_q    <= ST_BURST;
                beat_cnt_q <= req1_burst;
              end
            end
          end
        end
        ST_BURST: begin
          // The counter is at least 1 here, so it stops at 0 on the final beat.
          if (accept1) begin
            beat_cnt_q <= beat_cnt_q - 4'd1;
            if (beat_cnt_q == 4'd1) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign reg_aload  = reg_aload_q;
  assign reg_adata  = INIT_VALUE;
  assign reg_we     = reg_we_q;
  assign reg_wdata  = reg_wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_reg128_write_arb.sv
// tb/tb_reg128_write_arb.sv - randomized and directed bench for reg128_write_arb
// A transaction-level model predicts grants and register writes each cycle.
module tb_reg128_write_arb;

  localparam logic [127:0] INIT_V = 128'hC0DE_0000_1111_2222_3333_4444_5555_A5A5;

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic [127:0] req0_data = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [127:0] req1_data = '0;
  logic [3:0]   req1_burst = '0;
  logic         req1_ready;
  logic         init_req = 1'b0;
  logic         reg_aload;
  logic [127:0] reg_adata;
  logic         reg_we;
  logic [127:0] reg_wdata;
  logic         busy;
  logic         last_grant;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pending init cycle, remaining exclusive beats, who wins a tie.
  bit           m_init = 1'b1;
  int           m_beats = 0;
  bit           m_fav1 = 1'b0;
  bit           e_we = 1'b0;
  logic [127:0] e_wdata = '0;
  bit           e_aload = 1'b0;
  bit           e_last = 1'b0;

  reg128_write_arb #(.INIT_VALUE(INIT_V)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_burst (req1_burst),
    .req1_ready (req1_ready),
    .init_req   (init_req),
    .reg_aload  (reg_aload),
    .reg_adata  (reg_adata),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .busy       (busy),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle(input bit rn, input bit v0, input logic [127:0] d0, input bit v1,
                       input logic [127:0] d1, input logic [3:0] b, input bit ir);
    bit r0, r1, a0, a1;
    areset_n   = rn;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    req1_burst = b;
    init_req   = ir;
    if (!rn) begin
      m_init = 1'b1; m_beats = 0; m_fav1 = 1'b0;
      e_we = 1'b0; e_wdata = '0; e_aload = 1'b0; e_last = 1'b0;
    end
    r0 = 1'b0;
    r1 = 1'b0;
    if (rn && !m_init) begin
      if (m_beats > 0) r1 = 1'b1;
      else if (!ir) begin
        if (v0 && v1) begin
          r0 = !m_fav1;
          r1 = m_fav1;
        end else begin
          r0 = v0;
          r1 = v1;
        end
      end
    end
    #3;
    check_eq("req0_ready", 128'(req0_ready), 128'(r0));
    check_eq("req1_ready", 128'(req1_ready), 128'(r1));
    check_eq("reg_we", 128'(reg_we), 128'(e_we));
    check_eq("reg_wdata", reg_wdata, e_wdata);
    check_eq("reg_aload", 128'(reg_aload), 128'(e_aload));
    check_eq("last_grant", 128'(last_grant), 128'(e_last));
    check_eq("busy", 128'(busy), 128'(!rn || m_init || m_beats > 0));
    check_eq("reg_adata", reg_adata, INIT_V);
    if (rn) begin
      a0 = v0 && r0;
      a1 = v1 && r1;
      e_aload = m_init;
      e_we = a0 || a1;
      if (a0) begin
        e_wdata = d0; e_last = 1'b0;
      end else if (a1) begin
        e_wdata = d1; e_last = 1'b1;
      end
      if (m_init) m_init = 1'b0;
      else if (m_beats > 0) begin
        if (a1) begin
          m_beats--;
          if (m_beats == 0) m_fav1 = 1'b0;
        end
      end else if (ir) m_init = 1'b1;
      else begin
        if (a0) m_fav1 = 1'b1;
        if (a1) begin
          m_fav1 = 1'b0;
          m_beats = int'(b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, 4'd0, 1'b0);
  endtask

  initial begin
    logic [127:0] da, db;
    @(posedge clk);
    #1;
    // Reset, then a quiet release: one aload pulse and an idle arbiter.
    cycle(1'b0, 1'b1, rand128(), 1'b1, rand128(), 4'd2, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 4'd0, 1'b0);
    idle(4);

    // Both requesters valid with fixed data: alternating grants.
    da = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    db = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, da, 1'b1, db, 4'd0, 1'b0);
    idle(2);

    // Burst of 3 extra beats with requester 0 pending throughout.
    cycle(1'b1, 1'b1, da, 1'b0, '0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, da, 1'b1, rand128(), 4'd3, 1'b0);
    idle(2);

    // init_req raised with two burst beats outstanding.
    cycle(1'b1, 1'b0, '0, 1'b1, rand128(), 4'd3, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, rand128(), 4'd7, 1'b0);
    cycle(1'b1, 1'b1, rand128(), 1'b1, rand128(), 4'd7, 1'b1);
    cycle(1'b1, 1'b1, rand128(), 1'b1, rand128(), 4'd7, 1'b1);
    cycle(1'b1, 1'b1, rand128(), 1'b1, rand128(), 4'd0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 4'd0, 1'b0);
    idle(2);

    // Reset pulse in the middle of a burst.
    cycle(1'b1, 1'b0, '0, 1'b1, rand128(), 4'd5, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, rand128(), 4'd0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, rand128(), 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1, rand128(), 4'd0, 1'b0);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) != 0), rand128(),
            ($urandom_range(0, 2) != 0), rand128(),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0,
            ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg128_write_arb.md
REG128_WRITE_ARB -- requirements
Module: reg128_write_arb

Interface
REQ-001 Parameter INIT_VALUE, default 128'h0, value loaded into the register on every init sequence.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 areset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 (writeback) has a write beat.
REQ-005 req0_data  input  128  requester 0 write data.
REQ-006 req0_ready  output  1  requester 0 beat accepted this cycle when valid&ready.
REQ-007 req1_valid  input  1  requester 1 (load/debug) has a write beat.
REQ-008 req1_data  input  128  requester 1 write data.
REQ-009 req1_burst  input  4  extra exclusive beats requested; sampled with req1's first accepted beat.
REQ-010 req1_ready  output  1  requester 1 beat accepted when valid&ready.
REQ-011 init_req  input  1  level request to reload INIT_VALUE.
REQ-012 reg_aload  output  1  drives register asynchronous-load; registered, glitch-free.
REQ-013 reg_adata  output  128  constant INIT_VALUE.
REQ-014 reg_we  output  1  register write enable; registered.
REQ-015 reg_wdata  output  128  register write data; registered.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 last_grant  output  1  id of requester owning the most recent accepted beat.

Function
REQ-018 FSM states SHALL be INIT, IDLE, BURST.
REQ-019 INIT SHALL last exactly one cycle: reg_aload=1, both readys 0, reg_we=0; next state IDLE.
REQ-020 In IDLE with init_req=1, both readys SHALL be 0 and next state SHALL be INIT; init_req has priority over requests.
REQ-021 In IDLE, readys SHALL be combinational: only one valid requester -> that requester ready; both valid -> requester selected by round-robin pointer ready, other 0; never both ready.
REQ-022 Round-robin pointer SHALL point to the requester not granted by the latest IDLE acceptance; reset value favours requester 0.
REQ-023 Accepted beat in cycle N SHALL produce reg_we=1 and reg_wdata=that beat's data in cycle N+1 (one-cycle latency); reg_we=0 in cycles with no acceptance; reg_wdata holds its last value when reg_we=0.
REQ-024 req1 accepted in IDLE with req1_burst=B>0 SHALL enter BURST with beat counter=B; B=0 stays in IDLE.
REQ-025 In BURST, req1_ready=req1_valid-independent 1, req0_ready=0; each accepted req1 beat decrements counter; acceptance at counter=1 returns to IDLE next cycle.
REQ-026 req1_burst SHALL be ignored on beats inside BURST; counter never wraps below 0.
REQ-027 init_req during BURST SHALL be deferred (held level honoured once IDLE is reached).
REQ-028 After BURST exit, round-robin pointer SHALL favour requester 0.
REQ-029 last_grant SHALL update in cycle N+1 for a beat accepted in cycle N.

Reset
REQ-030 While areset_n=0: state=INIT, reg_aload=0, reg_we=0, reg_wdata=0, both readys 0, busy=1, last_grant=0, pointer=0, counter=0.
REQ-031 The first rising edge after areset_n release SHALL execute the INIT cycle (reg_aload=1 in the following cycle only).
REQ-032 Reset asserted mid-BURST SHALL abandon the burst immediately; no reg_we pulse follows.

Verification
REQ-033 Release reset, no requests -> reg_aload=1 for exactly one cycle, then busy=0, reg_we=0.
REQ-034 Both valid every cycle, data0=A, data1=B, 4 cycles -> reg_wdata sequence A,B,A,B, one cycle later each, reg_we continuous.
REQ-035 req1_burst=3, req1 valid 4 beats, req0 valid throughout -> 4 consecutive req1 writes, req0_ready=0 throughout, then req0 granted next.
REQ-036 init_req=1 during BURST with 2 beats left -> 2 beats complete, then one reg_aload cycle, no write that cycle.
REQ-037 areset_n pulsed low mid-BURST -> reg_we=0 immediately, INIT after release, burst not resumed.
